postadder_normalizer: RTL and testbench
=======================================

Name: postadder_normalizer

Overview:
- Back end of the float adder datapath. Takes the signed magnitude sum from the mantissa adder, together with the common exponent and the alignment loss bits from the pre-adder stage.
- Normalizes the sum iteratively, one left shift per cycle. Rounds to nearest-even and packs an IEEE-754 single-precision result.
- Sits between the mantissa adder and the result register, with a valid/ready handshake on both sides.

Parameters:
- EXP_W, 8, exponent width (only 8 is verified).
- TRUNCATE, 0, 0 = round-to-nearest-even; 1 = truncate (no increment, inexact still reported).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept; high only in IDLE.
- sign  input  1  sign of result (sign_of_great after add).
- exp  input  EXP_W  biased common exponent; 0 treated as effective exponent 1.
- sum  input  29  magnitude. Bit 28 = carry; bit 27 = hidden; 26:4 = fraction; 3 = guard; 2 = round; 1:0 = sticky.
- loss  input  2  alignment loss bits; ORed into sticky.
- result  output  32  packed {sign, exp[7:0], frac[22:0]}.
- inexact  output  1  any nonzero bit discarded (guard/round/sticky/loss).
- overflow  output  1  result rounded or carried to infinity.
- out_valid  output  1  result valid; held until out_ready.
- out_ready  input  1  downstream accepts.

Behaviour:
- Reset: state=IDLE; in_ready=1, out_valid=0, result=0, inexact=0, overflow=0.
  - rst mid-operation (any state) aborts the op; the captured operand is discarded.
- States: IDLE, NORM, ROUND, DONE.
- IDLE, on in_valid && in_ready (capture edge):
  - Latch sign.
  - E = (exp==0) ? 1 : exp.
  - M = sum.
  - S = |loss.
  - If sum==0: result={sign,31'b0}, inexact=S, overflow=0, go DONE.
  - Else if M[28]: M=M>>1, S|=dropped bit, E=E+1.
    - If E then equals 255: result={sign,8'hFF,23'b0}, overflow=1, inexact=1, go DONE.
  - Otherwise go NORM.
- NORM, each cycle:
  - If M[27]==0 && E>1: M=M<<1, E=E-1, stay in NORM.
  - Else go ROUND.
  - One shift per cycle, at most 27 shifts.
- ROUND, single cycle:
  - g = M[3]; rs = M[2] | M[1] | M[0] | S; lsb = M[4].
  - inexact = g | rs.
  - Increment M[27:4] by 1 if TRUNCATE==0 && g && (rs || lsb).
  - Increment carries into bit 28: mantissa = 0, E = E+1.
  - Exp field = M[27] ? E : 0 (subnormal).
    - A subnormal that rounds up into bit 27 naturally gets exp field 1.
  - E==255 after carry: result = signed infinity, overflow=1.
  - Then go DONE with result registered.
- DONE:
  - out_valid=1; result, inexact and overflow held stable.
  - On out_ready: out_valid=0 and go IDLE on the same edge.
  - in_ready stays 0 until the IDLE cycle; there is no accept in the DONE→IDLE cycle.
- Latency:
  - k = number of NORM shifts.
  - out_valid asserts k+2 cycles after the capture edge.
  - Zero and carry-overflow cases: 1 cycle after capture.
- Throughput: one op in flight; no buffering.
- Arithmetic is unsigned on M.
- Sign is passed through unchanged, including zero results.

Test Plan:
- 1.0: sign=0, exp=8'h7F, sum=29'h08000000, loss=0 → result 32'h3F800000, inexact=0, out_valid 2 cycles after capture.
- Carry: exp=8'h7F, sum=29'h10000000 → 32'h40000000. exp=8'hFE, sum=29'h10000000 → 32'h7F800000, overflow=1.
- Normalize: exp=8'h7F, sum=29'h02000000 → 2 shifts, 32'h3E800000, out_valid 4 cycles after capture. exp=8'h02, sum=29'h00000010 → subnormal, exp field 0, nonzero frac.
- Round: exp=8'h7F, sum=29'h0FFFFFF8 (guard=1) → 32'h40000000, inexact=1. Tie with even lsb, sum=29'h08000008 → 32'h3F800000, inexact=1.
- Zero/handshake: sign=1, sum=0 → 32'h80000000. Hold out_ready=0 for 5 cycles → out_valid and result stable, in_ready=0.
- Reset mid-op: assert rst during NORM → next cycle in_ready=1, out_valid=0. A following 1.0 op produces correct 32'h3F800000.

Source files
------------

// File: rtl/postadder_normalizer.sv
// Float-add back end: normalizes the adder sum one shift per cycle,
// rounds to nearest-even (or truncates) and packs an IEEE-754 single.
// Ports: clk, rst (sync, active-high); in_valid/in_ready operand handshake
// carrying sign, exp, sum[28:0], loss[1:0]; out_valid/out_ready result
// handshake carrying result[31:0], inexact, overflow.
module postadder_normalizer #(
  parameter int EXP_W    = 8,
  parameter bit TRUNCATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign,
  input  logic [EXP_W-1:0] exp,
  input  logic [28:0]      sum,
  input  logic [1:0]       loss,
  output logic [31:0]      result,
  output logic             inexact,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } state_t;

  localparam logic [EXP_W:0] ONE  = {{EXP_W{1'b0}}, 1'b1};
  localparam logic [EXP_W:0] EMAX = {1'b0, {EXP_W{1'b1}}};

  state_t         r_state, w_state;
  logic           r_sign, w_sign;
  logic [EXP_W:0] r_e, w_e;
  logic [28:0]    r_m, w_m;
  logic           r_s, w_s;
  logic [31:0]    r_result, w_result;
  logic           r_inexact, w_inexact;
  logic           r_overflow, w_overflow;

  // Capture-side helpers
  logic [EXP_W:0] w_e_in;
  logic [EXP_W:0] w_e_inc;

  assign w_e_in  = (exp == '0) ? ONE : {1'b0, exp};
  assign w_e_inc = w_e_in + ONE;

  // Rounding helpers
  logic           w_g;
  logic           w_rs;
  logic           w_inc;
  logic [24:0]    w_rnd;
  logic [EXP_W:0] w_e_rnd;
  logic [EXP_W:0] w_ef;
  logic [22:0]    w_frac;

  assign w_g     = r_m[3];
  assign w_rs    = r_m[2] | r_m[1] | r_m[0] | r_s;
  assign w_inc   = !TRUNCATE && w_g && (w_rs || r_m[4]);
  assign w_rnd   = {1'b0, r_m[27:4]} + {24'b0, w_inc};
  // A carry out of the hidden bit renormalizes to 1.0 x 2^(E+1)
  assign w_e_rnd = w_rnd[24] ? r_e + ONE : r_e;
  assign w_frac  = w_rnd[24] ? 23'b0 : w_rnd[22:0];
  assign w_ef    = (w_rnd[24] || w_rnd[23]) ? w_e_rnd : '0;

  always_comb begin
    w_state    = r_state;
    w_sign     = r_sign;
    w_e        = r_e;
    w_m        = r_m;
    w_s        = r_s;
    w_result   = r_result;
    w_inexact  = r_inexact;
    w_overflow = r_overflow;
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_sign = sign;
          w_s    = |loss;
          w_e    = w_e_in;
          w_m    = sum;
          if (sum == '0) begin
            w_result   = {sign, 31'b0};
            w_inexact  = |loss;
            w_overflow = 1'b0;
            w_state    = DONE;
          end else if (sum[28]) begin
            w_m = sum >> 1;
            w_s = (|loss) | sum[0];
            w_e = w_e_inc;
            if (w_e_inc == EMAX) begin
              w_result   = {sign, 8'hFF, 23'b0};
              w_inexact  = 1'b1;
              w_overflow = 1'b1;
              w_state    = DONE;
            end else begin
              w_state = NORM;
            end
          end else begin
            w_state = NORM;
          end
        end
      end
      NORM: begin
        if (!r_m[27] && (r_e > ONE)) begin
          w_m = r_m << 1;
          w_e = r_e - ONE;
        end else begin
          w_state = ROUND;
        end
      end
      ROUND: begin
        w_result   = {r_sign, w_ef[EXP_W-1:0], w_frac};
        w_inexact  = w_g | w_rs;
        w_overflow = w_rnd[24] && (w_e_rnd == EMAX);
        w_state    = DONE;
      end
      DONE: begin
        if (out_ready) w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_sign     <= 1'b0;
      r_e        <= '0;
      r_m        <= '0;
      r_s        <= 1'b0;
      r_result   <= '0;
      r_inexact  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_sign     <= w_sign;
      r_e        <= w_e;
      r_m        <= w_m;
      r_s        <= w_s;
      r_result   <= w_result;
      r_inexact  <= w_inexact;
      r_overflow <= w_overflow;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign inexact   = r_inexact;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_postadder_normalizer.sv
// Directed bench for postadder_normalizer: hand-computed vectors for
// normal, carry, normalize, subnormal, rounding, zero, hold and reset cases.
module tb_postadder_normalizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        sign;
  logic [7:0]  exp;
  logic [28:0] sum;
  logic [1:0]  loss;
  logic [31:0] result;
  logic        inexact;
  logic        overflow;
  logic        out_valid;
  logic        out_ready;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  postadder_normalizer #(.EXP_W(8), .TRUNCATE(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign      (sign),
    .exp       (exp),
    .sum       (sum),
    .loss      (loss),
    .result    (result),
    .inexact   (inexact),
    .overflow  (overflow),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Issue one op, wait for the result, check it, optionally hold, drain.
  task automatic do_op(input string tag, input logic s, input logic [7:0] e,
                       input logic [28:0] m, input logic [1:0] l,
                       input logic [31:0] x_res, input logic x_inx,
                       input logic x_ovf, input int x_lat, input int hold);
    int lat;
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    sign     = s;
    exp      = e;
    sum      = m;
    loss     = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    if (x_lat >= 0) chk({tag, "_latency"}, lat, x_lat);
    chk({tag, "_result"}, result, x_res);
    chk({tag, "_inexact"}, {31'b0, inexact}, {31'b0, x_inx});
    chk({tag, "_overflow"}, {31'b0, overflow}, {31'b0, x_ovf});
    chk({tag, "_busy"}, {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
      chk({tag, "_hold_result"}, result, x_res);
      chk({tag, "_hold_in_ready"}, {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_drain_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_drain_in_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sign      = 1'b0;
    exp       = 8'h00;
    sum       = '0;
    loss      = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_inexact", {31'b0, inexact}, 32'd0);
    chk("rst_overflow", {31'b0, overflow}, 32'd0);

    do_op("one", 1'b0, 8'h7F, 29'h08000000, 2'b00,
          32'h3F800000, 1'b0, 1'b0, 2, 0);
    do_op("carry", 1'b0, 8'h7F, 29'h10000000, 2'b00,
          32'h40000000, 1'b0, 1'b0, -1, 0);
    do_op("carry_ovf", 1'b0, 8'hFE, 29'h10000000, 2'b00,
          32'h7F800000, 1'b1, 1'b1, -1, 0);
    do_op("norm2", 1'b0, 8'h7F, 29'h02000000, 2'b00,
          32'h3E800000, 1'b0, 1'b0, 4, 0);
    do_op("subnorm", 1'b0, 8'h02, 29'h00000010, 2'b00,
          32'h00000002, 1'b0, 1'b0, 3, 0);
    do_op("rnd_carry", 1'b0, 8'h7F, 29'h0FFFFFF8, 2'b00,
          32'h40000000, 1'b1, 1'b0, 2, 0);
    do_op("tie_even", 1'b0, 8'h7F, 29'h08000008, 2'b00,
          32'h3F800000, 1'b1, 1'b0, 2, 0);
    do_op("tie_odd", 1'b1, 8'h7F, 29'h08000018, 2'b00,
          32'hBF800002, 1'b1, 1'b0, 2, 0);
    do_op("loss_sticky", 1'b0, 8'h7F, 29'h08000000, 2'b01,
          32'h3F800000, 1'b1, 1'b0, 2, 0);
    do_op("exp_zero", 1'b0, 8'h00, 29'h08000000, 2'b00,
          32'h00800000, 1'b0, 1'b0, 2, 0);
    do_op("rnd_ovf", 1'b0, 8'hFE, 29'h0FFFFFF8, 2'b00,
          32'h7F800000, 1'b1, 1'b1, 2, 0);
    do_op("zero_loss", 1'b0, 8'h40, 29'h00000000, 2'b10,
          32'h00000000, 1'b1, 1'b0, -1, 0);
    do_op("zero_hold", 1'b1, 8'h7F, 29'h00000000, 2'b00,
          32'h80000000, 1'b0, 1'b0, -1, 5);

    in_valid = 1'b1;
    sign     = 1'b0;
    exp      = 8'h7F;
    sum      = 29'h00000010;
    loss     = 2'b00;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", {31'b0, in_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    repeat (30) @(posedge clk);
    #1;
    chk("mid_rst_no_result", {31'b0, out_valid}, 32'd0);
    do_op("after_rst", 1'b0, 8'h7F, 29'h08000000, 2'b00,
          32'h3F800000, 1'b0, 1'b0, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
